// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the 5-stage pipeline: owns HI/LO, counts out the
// fixed operation latency and stalls D while a HI/LO user would conflict.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_hilo_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_HILOout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;

  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [4:0]  count_r, count_nxt_s;
  logic [31:0] hi_r, hi_nxt_s;
  logic [31:0] lo_r, lo_nxt_s;
  logic [31:0] pend_hi_r, pend_hi_nxt_s;
  logic [31:0] pend_lo_r, pend_lo_nxt_s;
  logic        pend_wr_r, pend_wr_nxt_s;

  logic [63:0] mul_s;
  logic [63:0] mulu_s;
  logic [63:0] div_s;
  logic [63:0] divu_s;
  logic        divz_s;

  // Signed divide on magnitudes so MIN/-1 wraps to MIN cleanly; returns {rem, quo}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    a_mag = a[31] ? (32'd0 - a) : a;
    b_mag = b[31] ? (32'd0 - b) : b;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    return {(a[31] ? (32'd0 - r_mag) : r_mag),
            ((a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag)};
  endfunction

  // Unsigned divide; returns {rem, quo}, zero divisor yields zeros (never committed).
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] res;
    if (b == 32'd0) begin
      res = 64'd0;
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  assign mul_s  = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
  assign mulu_s = {32'd0, E_A} * {32'd0, E_B};
  assign div_s  = div_signed(E_A, E_B);
  assign divu_s = div_unsigned(E_A, E_B);
  assign divz_s = (E_B == 32'd0);

  // Next-state and datapath update for the IDLE/RUN sequencer.
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = count_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_wr_nxt_s = pend_wr_r;
    case (state_r)
      ST_IDLE: begin
        if (E_start) begin
          case (E_op)
            OP_MULT: begin
              state_nxt_s   = ST_RUN;
              count_nxt_s   = MULT_N;
              pend_hi_nxt_s = mul_s[63:32];
              pend_lo_nxt_s = mul_s[31:0];
              pend_wr_nxt_s = 1'b1;
            end
            OP_MULTU: begin
              state_nxt_s   = ST_RUN;
              count_nxt_s   = MULT_N;
              pend_hi_nxt_s = mulu_s[63:32];
              pend_lo_nxt_s = mulu_s[31:0];
              pend_wr_nxt_s = 1'b1;
            end
            OP_DIV: begin
              state_nxt_s   = ST_RUN;
              count_nxt_s   = DIV_N;
              pend_hi_nxt_s = div_s[63:32];
              pend_lo_nxt_s = div_s[31:0];
              pend_wr_nxt_s = ~divz_s;
            end
            OP_DIVU: begin
              state_nxt_s   = ST_RUN;
              count_nxt_s   = DIV_N;
              pend_hi_nxt_s = divu_s[63:32];
              pend_lo_nxt_s = divu_s[31:0];
              pend_wr_nxt_s = ~divz_s;
            end
            OP_MTHI: hi_nxt_s = E_A;
            OP_MTLO: lo_nxt_s = E_A;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A count of 0 in RUN cannot occur legally; retire rather than wrap.
        if (count_r <= 5'd1) begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = 5'd0;
          if (pend_wr_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          count_nxt_s = count_r - 5'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = 5'd0;
      end
    endcase
  end

  // State, counter and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      count_r   <= 5'd0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_wr_r <= pend_wr_nxt_s;
    end
  end

  assign busy      = (state_r == ST_RUN);
  assign HI        = hi_r;
  assign LO        = lo_r;
  assign E_HILOout = (E_op == OP_MFHI) ? hi_r : lo_r;
  assign stall     = D_hilo_use & (busy | (E_start & (E_op >= OP_MULT) & (E_op <= OP_DIVU)));

endmodule
